// File: rtl/quant_zigzag_buf_if.sv
// Handshake bundle between the quantisation multiplier, the zigzag buffer and
// the run-length stage: raster products in, zigzag-ordered coefficients out.
interface quant_zigzag_buf_if #(
  parameter int OUT_W = 11
) ();
  logic             in_valid;
  logic             in_ready;
  logic [34:0]      in_mag;
  logic             in_sign;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [5:0]       out_idx;
  logic             out_last;

  modport master (
    output in_valid, in_mag, in_sign, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_mag, in_sign, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/quant_zigzag_buf.sv
// Rounds, saturates and re-signs quantiser products, then reorders each
// 64-coefficient block from raster to zigzag order through a ping-pong buffer.
module quant_zigzag_buf #(
  parameter int FRAC_BITS = 11,
  parameter int OUT_W     = 11
) (
  input  logic               clk,
  input  logic               rst,
  quant_zigzag_buf_if.slave  bus
);

  localparam int MAG_W = 35;
  localparam int ACC_W = 36;
  localparam logic [ACC_W-1:0] HALF = 36'd1 << (FRAC_BITS - 1);
  localparam logic [ACC_W-1:0] MAXV = (36'd1 << (OUT_W - 1)) - 36'd1;

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [ACC_W-1:0] round_mag(input logic [MAG_W-1:0] mag);
    logic [ACC_W-1:0] sum;
    sum = {1'b0, mag} + HALF;
    return sum >> FRAC_BITS;
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_sign(input logic [ACC_W-1:0] r,
                                                       input logic neg);
    logic signed [OUT_W-1:0] m;
    if (r > MAXV) m = signed'(MAXV[OUT_W-1:0]);
    else          m = signed'(r[OUT_W-1:0]);
    // Magnitude never exceeds 2^(OUT_W-1)-1, so negation cannot overflow and -0 is 0.
    return neg ? -m : m;
  endfunction

  logic signed [OUT_W-1:0] mem [128];

  logic [1:0]              full_q, full_d;
  logic                    wbank_q, wbank_d;
  logic                    rbank_q, rbank_d;
  logic [5:0]              wcnt_q, wcnt_d;
  logic [5:0]              rk_q, rk_d;
  logic                    done_q, done_d;
  logic                    ov_q, ov_d;
  logic signed [OUT_W-1:0] od_q, od_d;
  logic [5:0]              oidx_q, oidx_d;
  logic                    olast_q, olast_d;

  logic in_fire, out_fire, rel, lbank, lpend, load;

  always_comb begin
    in_fire  = bus.in_valid & ~full_q[wbank_q];
    out_fire = ov_q & bus.out_ready;
    rel      = out_fire & olast_q;
    // On the cycle a bank is released the next full bank can load immediately,
    // so consecutive blocks stream without a bubble.
    lbank    = rel ? ~rbank_q : rbank_q;
    lpend    = full_q[lbank] & (rel | ~done_q);
    load     = lpend & (~ov_q | bus.out_ready);

    full_d  = full_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    wcnt_d  = wcnt_q;
    rk_d    = rk_q;
    done_d  = done_q;
    ov_d    = ov_q;
    od_d    = od_q;
    oidx_d  = oidx_q;
    olast_d = olast_q;

    if (in_fire) begin
      wcnt_d = wcnt_q + 6'd1;
      if (wcnt_q == 6'd63) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end

    if (rel) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = ~rbank_q;
      done_d          = 1'b0;
    end

    if (out_fire) ov_d = 1'b0;

    if (load) begin
      ov_d    = 1'b1;
      od_d    = mem[{lbank, ZZ[rk_q]}];
      oidx_d  = rk_q;
      olast_d = (rk_q == 6'd63);
      rk_d    = rk_q + 6'd1;
      done_d  = (rk_q == 6'd63);
    end
  end

  // Write stage: quantise and store at the raster address of the write bank
  always_ff @(posedge clk) begin
    if (in_fire) mem[{wbank_q, wcnt_q}] <= sat_sign(round_mag(bus.in_mag), bus.in_sign);
  end

  // Read stage: control state and the registered output slot
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q  <= 2'b00;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      wcnt_q  <= 6'd0;
      rk_q    <= 6'd0;
      done_q  <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      oidx_q  <= 6'd0;
      olast_q <= 1'b0;
    end else begin
      full_q  <= full_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wcnt_q  <= wcnt_d;
      rk_q    <= rk_d;
      done_q  <= done_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      oidx_q  <= oidx_d;
      olast_q <= olast_d;
    end
  end

  assign bus.in_ready  = ~full_q[wbank_q];
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_idx   = oidx_q;
  assign bus.out_last  = olast_q;

endmodule
